// File: rtl/vend_pkg.sv
// Shared vending-path types: coin codes and price, plus the single-coin encoder.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10
  } coin_t;

  localparam int unsigned NEWSPAPER_PRICE_CENTS = 15;

  // Code for exactly one coin event this edge; simultaneous or absent events map to none.
  function automatic coin_t coin_code(input logic nickel, input logic dime);
    if (nickel && !dime) return COIN_NICKEL;
    if (dime && !nickel) return COIN_DIME;
    return COIN_NONE;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/dispense inputs and coin outputs between the slot hardware, acceptor and vending FSM.
interface coin_acceptor_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  import vend_pkg::*;

  localparam int unsigned PEND_W = $clog2(FIFO_DEPTH) + 1;

  logic              nickel_sense;
  logic              dime_sense;
  logic              newspaper;
  coin_t             coin;
  logic              coin_return;
  logic [PEND_W-1:0] pending;

  modport master (
    output nickel_sense, dime_sense, newspaper,
    input  coin, coin_return, pending
  );

  modport slave (
    input  nickel_sense, dime_sense, newspaper,
    output coin, coin_return, pending
  );

endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus counter debounce for one slot sensor; pulses on a debounced rise.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  output logic rise_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             expire;

  assign differ = (sync2 != stable);
  assign expire = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_c = expire && !stable;

  // Synchronise the sensor, then flip the stable level after enough consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= sense;
      sync2 <= sync1;
      if (expire) begin
        stable <= ~stable;
        cnt    <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the coin sensors, buffers accepted coins and feeds them one per cycle to the vending FSM.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic            clock,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  coin_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             nickel_rise_c;
  logic             dime_rise_c;
  logic             empty;
  logic             pop;
  logic             full_after_pop;
  logic             push;
  logic             reject;
  coin_t            event_code;
  coin_t            head;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
    .clock  (clock),
    .reset  (reset),
    .sense  (bus.nickel_sense),
    .rise_c (nickel_rise_c)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
    .clock  (clock),
    .reset  (reset),
    .sense  (bus.dime_sense),
    .rise_c (dime_rise_c)
  );

  // Occupancy, issue gating and accept/reject decision; full is judged after this edge's pop.
  assign count          = wr_ptr - rd_ptr;
  assign empty          = (count == '0);
  assign head           = fifo_mem[rd_ptr[IDX_W-1:0]];
  assign pop            = !empty && !bus.newspaper;
  assign full_after_pop = ((count - PTR_W'(pop)) == PTR_W'(FIFO_DEPTH));
  assign event_code     = coin_code(nickel_rise_c, dime_rise_c);
  assign push           = (event_code != COIN_NONE) && !full_after_pop;
  assign reject         = (nickel_rise_c && dime_rise_c) ||
                          ((event_code != COIN_NONE) && full_after_pop);

  assign bus.coin    = pop ? head : COIN_NONE;
  assign bus.pending = count;

  // FIFO pointers and the one-cycle reject pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.coin_return <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      bus.coin_return <= reject;
    end
  end

  // Coin storage; contents are only read while the FIFO is non-empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= event_code;
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed, table-driven bench for coin_acceptor (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Row k drives the inputs sampled at edge k and checks outputs on the negedge before that edge.
module tb_coin_acceptor;
  import vend_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;

  logic clock;
  logic reset;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       nickel;
    logic       dime;
    logic       newspaper;
    logic [1:0] coin;
    logic       ret;
    logic [2:0] pending;
  } vec_t;

  vec_t vecs[$];

  coin_acceptor_if #(.FIFO_DEPTH(DEPTH)) bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int row, input int actual, input int want);
    checks++;
    if (actual != want) begin
      errors++;
      $display("FAIL %s row %0d: got %0d, want %0d", name, row, actual, want);
    end
  endtask

  task automatic apply_row(input string tag, input int row, input logic n, input logic d,
                           input logic np, input logic rst, input logic [1:0] c,
                           input logic r, input logic [2:0] p);
    bus.nickel_sense = n;
    bus.dime_sense   = d;
    bus.newspaper    = np;
    reset            = rst;
    @(negedge clock);
    check({tag, ".coin"}, row, int'(bus.coin), int'(c));
    check({tag, ".coin_return"}, row, int'(bus.coin_return), int'(r));
    check({tag, ".pending"}, row, int'(bus.pending), int'(p));
    @(posedge clock);
    #1;
  endtask

  task automatic add_vec(input logic n, input logic d, input logic np,
                         input logic [1:0] c, input logic r, input logic [2:0] p);
    vec_t v;
    v.nickel = n; v.dime = d; v.newspaper = np;
    v.coin = c; v.ret = r; v.pending = p;
    vecs.push_back(v);
  endtask

  // Expected occupancy while nickels pile up with newspaper held; pushes land on edge 12q+5.
  function automatic logic [2:0] held_pending(input int p, input int r);
    int n;
    n = (r >= 6) ? p + 1 : p;
    if (n > 4) n = 4;
    return 3'(n);
  endfunction

  initial begin
    int row;
    bus.nickel_sense = 1'b0;
    bus.dime_sense   = 1'b0;
    bus.newspaper    = 1'b0;
    reset            = 1'b1;
    $display("coin_acceptor bench, newspaper price %0d cents", NEWSPAPER_PRICE_CENTS);
    @(posedge clock);
    #1;
    apply_row("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0);

    // Single nickel held 10 cycles: coin in row 6 only, then fall debounces without an event.
    for (int k = 0; k < 18; k++)
      add_vec(k < 10, 1'b0, 1'b0, (k == 6) ? 2'd1 : 2'd0, 1'b0, (k == 6) ? 3'd1 : 3'd0);
    // Single dime held 8 cycles.
    for (int k = 0; k < 16; k++)
      add_vec(1'b0, k < 8, 1'b0, (k == 6) ? 2'd2 : 2'd0, 1'b0, (k == 6) ? 3'd1 : 3'd0);
    // Glitch: 3 sampled high cycles never flip the stable level.
    for (int k = 0; k < 9; k++)
      add_vec(1'b0, k < 3, 1'b0, 2'd0, 1'b0, 3'd0);
    // Simultaneous rise: rejected, no coin, pending unchanged.
    for (int k = 0; k < 16; k++)
      add_vec(k < 8, k < 8, 1'b0, 2'd0, k == 6, 3'd0);

    foreach (vecs[i])
      apply_row("table", i, vecs[i].nickel, vecs[i].dime, vecs[i].newspaper, 1'b0,
                vecs[i].coin, vecs[i].ret, vecs[i].pending);

    // Dispense hold: newspaper high around the push edge delays the dime by one cycle.
    for (int k = 0; k < 16; k++)
      apply_row("hold", k, 1'b0, k < 8, (k == 5) || (k == 6), 1'b0,
                (k == 7) ? 2'd2 : 2'd0, 1'b0, ((k == 6) || (k == 7)) ? 3'd1 : 3'd0);

    // Overflow: five nickels while held; the fifth is returned.
    row = 0;
    for (int p = 0; p < 5; p++)
      for (int r = 0; r < 12; r++) begin
        apply_row("ovf", row, r < 6, 1'b0, 1'b1, 1'b0, 2'd0, (p == 4) && (r == 6),
                  held_pending(p, r));
        row++;
      end
    // Drain: four consecutive nickels then nothing.
    for (int k = 0; k < 6; k++)
      apply_row("drain", k, 1'b0, 1'b0, 1'b0, 1'b0, (k < 4) ? 2'd1 : 2'd0, 1'b0,
                (k < 4) ? 3'(4 - k) : 3'd0);

    // Reset mid-operation: three buffered coins discarded, held nickel yields one fresh coin.
    row = 0;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 12; r++) begin
        apply_row("rstmid", row, r < 6, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, held_pending(p, r));
        row++;
      end
    for (int k = 0; k < 2; k++) begin
      apply_row("rstmid", row, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3);
      row++;
    end
    apply_row("rstmid", row, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 3'd3);
    for (int j = 1; j <= 12; j++)
      apply_row("after_rst", j, 1'b1, 1'b0, 1'b0, 1'b0, (j == 7) ? 2'd1 : 2'd0, 1'b0,
                (j == 7) ? 3'd1 : 3'd0);
    for (int k = 0; k < 8; k++)
      apply_row("idle", k, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
